// File: rtl/int_pkg.sv
// Shared constants and width helpers for the multi-channel integrator cascade.
package int_pkg;

    localparam int unsigned WinDefault = 38;
    localparam int unsigned WgDefault  = 0;
    localparam int unsigned NstDefault = 3;
    localparam int unsigned NchDefault = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Channel tag width, at least one bit so a single-channel build still has a port.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    // Internal and output width after word growth.
    function automatic int unsigned out_width(input int unsigned win, input int unsigned wg);
        return win + wg;
    endfunction

endpackage

// File: rtl/int_stage_mc.sv
// One integrator stage holding NCH per-channel accumulators on a TDM stream.
// Optional synchronous clear when INT_CASCADE_CLR_EN is defined.
module int_stage_mc
    import int_pkg::*;
#(
    parameter int unsigned Wout = 38,
    parameter int unsigned NCH  = 4,
    localparam int unsigned CW  = ch_width(NCH)
) (
    input  logic            clk,
    input  logic            rst,
`ifdef INT_CASCADE_CLR_EN
    input  logic            clr,
`endif
    input  logic            val_i,
    input  logic [CW-1:0]   ch_i,
    input  logic [Wout-1:0] x_i,
    output logic            val_o,
    output logic [CW-1:0]   ch_o,
    output logic [Wout-1:0] y_o
);

    logic [Wout-1:0] acc_q [NCH];
    logic [Wout-1:0] acc_d [NCH];
    logic            upd;
    logic [Wout-1:0] sum;
    logic            val_q;
    logic [CW-1:0]   ch_q;
    logic [Wout-1:0] y_q;

    // Select the addressed accumulator and add; the result feeds both the
    // accumulator and the output register so the output includes this sample.
    always_comb begin
        acc_d = acc_q;
        sum   = '0;
        upd   = val_i && (32'(ch_i) < NCH);
`ifdef INT_CASCADE_CLR_EN
        if (clr) begin
            upd = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                acc_d[c] = '0;
            end
        end
`endif
        for (int c = 0; c < NCH; c++) begin
            if (upd && (ch_i == CW'(c))) begin
                acc_d[c] = acc_q[c] + x_i;
                sum      = acc_d[c];
            end
        end
    end

    // Accumulator bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            acc_q <= acc_d;
        end
    end

    // Output register: valid follows the update, data and tag hold across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q <= 1'b0;
            ch_q  <= '0;
            y_q   <= '0;
        end else begin
            val_q <= upd;
            if (upd) begin
                ch_q <= ch_i;
                y_q  <= sum;
            end
        end
    end

    assign val_o = val_q;
    assign ch_o  = ch_q;
    assign y_o   = y_q;

endmodule

// File: rtl/int_cascade_mc.sv
// Cascade of NST multi-channel integrator stages for the CIC decimator.
// Define INT_CASCADE_CLR_EN to add a synchronous clear input.
module int_cascade_mc
    import int_pkg::*;
#(
    parameter int unsigned Win  = WinDefault,
    parameter int unsigned Wg   = WgDefault,
    parameter int unsigned NST  = NstDefault,
    parameter int unsigned NCH  = NchDefault,
    localparam int unsigned Wout = out_width(Win, Wg),
    localparam int unsigned CW   = ch_width(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef INT_CASCADE_CLR_EN
    input  logic                   clr,
`endif
    input  logic                   val_in,
    input  logic [CW-1:0]          ch_in,
    input  logic signed [Win-1:0]  data_in,
    output logic                   val_out,
    output logic [CW-1:0]          ch_out,
    output logic signed [Wout-1:0] data_out
);

    // Index 0 is the block input, index k the registered output of stage k.
    logic [NST:0]           stg_val;
    logic [NST:0][CW-1:0]   stg_ch;
    logic [NST:0][Wout-1:0] stg_y;

    assign stg_val[0] = val_in;
    assign stg_ch[0]  = ch_in;
    assign stg_y[0]   = Wout'(data_in);

    for (genvar k = 0; k < NST; k++) begin : g_stage
        int_stage_mc #(
            .Wout (Wout),
            .NCH  (NCH)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
`ifdef INT_CASCADE_CLR_EN
            .clr   (clr),
`endif
            .val_i (stg_val[k]),
            .ch_i  (stg_ch[k]),
            .x_i   (stg_y[k]),
            .val_o (stg_val[k+1]),
            .ch_o  (stg_ch[k+1]),
            .y_o   (stg_y[k+1])
        );
    end

    assign val_out  = stg_val[NST];
    assign ch_out   = stg_ch[NST];
    assign data_out = stg_y[NST];

endmodule
